// File: rtl/ov7670_frame_stats.sv
// OV7670 RGB565 frame statistics: per-frame channel averages, green-object row span
// and pixel count, published through a valid/ready output register.
module ov7670_frame_stats #(
  parameter int AVG_SHIFT = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [7:0]  cam_d,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_pclk,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  avg_red,
  output logic [7:0]  avg_green,
  output logic [7:0]  avg_blue,
  output logic [7:0]  height_rows,
  output logic [15:0] pix_count,
  output logic        frame_overrun,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_PUBLISH = 2'd2} state_t;

  state_t      state_q;
  logic [1:0]  pclk_q, href_q, vsync_q;
  logic        pclk_prev_q, href_prev_q, vsync_prev_q;
  logic [7:0]  d1_q, d2_q;
  logic        phase_q;
  logic [4:0]  r5_q;
  logic [2:0]  ghi_q;
  logic [23:0] sum_r_q, sum_g_q, sum_b_q;
  logic [15:0] cnt_q;
  logic [7:0]  row_q, min_row_q, max_row_q;
  logic        any_green_q;
  logic        out_valid_q, overrun_q, busy_q;
  logic [7:0]  avg_r_q, avg_g_q, avg_b_q, height_q;
  logic [15:0] pix_q;

  logic        byte_stb_s, vs_fall_s, vs_rise_s, href_fall_s, green_s;
  logic [5:0]  g6_s;
  logic [4:0]  b5_s;
  logic [23:0] sum_r_d, sum_g_d, sum_b_d;
  logic [15:0] cnt_d;
  logic [7:0]  height_d;

  function automatic logic [23:0] sat_add24(input logic [23:0] a, input logic [7:0] b);
    logic [24:0] t;
    t = {1'b0, a} + {17'd0, b};
    return t[24] ? 24'hFFFFFF : t[23:0];
  endfunction

  function automatic logic [7:0] avg8(input logic [23:0] s);
    logic [23:0] sh;
    sh = s >> AVG_SHIFT;
    return (sh > 24'd255) ? 8'hFF : sh[7:0];
  endfunction

  assign byte_stb_s  = pclk_q[1] & ~pclk_prev_q;
  assign vs_fall_s   = ~vsync_q[1] & vsync_prev_q;
  assign vs_rise_s   = vsync_q[1] & ~vsync_prev_q;
  assign href_fall_s = ~href_q[1] & href_prev_q;
  // Second byte of a pixel is on d2_q; the first byte's fields were latched in r5_q/ghi_q.
  assign g6_s        = {ghi_q, d2_q[7:5]};
  assign b5_s        = d2_q[4:0];
  assign green_s     = (g6_s > {r5_q, 1'b0}) && (g6_s > {b5_s, 1'b0});
  assign sum_r_d     = sat_add24(sum_r_q, {r5_q, 3'b000});
  assign sum_g_d     = sat_add24(sum_g_q, {g6_s, 2'b00});
  assign sum_b_d     = sat_add24(sum_b_q, {b5_s, 3'b000});
  assign cnt_d       = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign height_d    = any_green_q ? (max_row_q - min_row_q + 8'd1) : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_q       <= 2'b00;
      href_q       <= 2'b00;
      vsync_q      <= 2'b00;
      pclk_prev_q  <= 1'b0;
      href_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
      d1_q         <= 8'd0;
      d2_q         <= 8'd0;
    end else begin
      pclk_q       <= {pclk_q[0], cam_pclk};
      href_q       <= {href_q[0], cam_href};
      vsync_q      <= {vsync_q[0], cam_vsync};
      pclk_prev_q  <= pclk_q[1];
      href_prev_q  <= href_q[1];
      vsync_prev_q <= vsync_q[1];
      d1_q         <= cam_d;
      d2_q         <= d1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      avg_r_q     <= 8'd0;
      avg_g_q     <= 8'd0;
      avg_b_q     <= 8'd0;
      height_q    <= 8'd0;
      pix_q       <= 16'd0;
      sum_r_q     <= 24'd0;
      sum_g_q     <= 24'd0;
      sum_b_q     <= 24'd0;
      cnt_q       <= 16'd0;
      row_q       <= 8'd0;
      min_row_q   <= 8'hFF;
      max_row_q   <= 8'd0;
      any_green_q <= 1'b0;
      phase_q     <= 1'b0;
      r5_q        <= 5'd0;
      ghi_q       <= 3'd0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (ena && vs_fall_s) begin
            state_q     <= ST_ACTIVE;
            busy_q      <= 1'b1;
            sum_r_q     <= 24'd0;
            sum_g_q     <= 24'd0;
            sum_b_q     <= 24'd0;
            cnt_q       <= 16'd0;
            row_q       <= 8'd0;
            min_row_q   <= 8'hFF;
            max_row_q   <= 8'd0;
            any_green_q <= 1'b0;
            phase_q     <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (!ena) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (vs_rise_s) begin
              state_q <= ST_PUBLISH;
              busy_q  <= 1'b0;
            end
            if (href_fall_s && (row_q != 8'hFF)) begin
              row_q <= row_q + 8'd1;
            end
            if (!href_q[1]) begin
              phase_q <= 1'b0;
            end else if (byte_stb_s) begin
              phase_q <= ~phase_q;
              if (!phase_q) begin
                r5_q  <= d2_q[7:3];
                ghi_q <= d2_q[2:0];
              end else begin
                sum_r_q <= sum_r_d;
                sum_g_q <= sum_g_d;
                sum_b_q <= sum_b_d;
                cnt_q   <= cnt_d;
                if (green_s) begin
                  any_green_q <= 1'b1;
                  if (row_q < min_row_q) min_row_q <= row_q;
                  if (row_q > max_row_q) max_row_q <= row_q;
                end
              end
            end
          end
        end
        ST_PUBLISH: begin
          state_q <= ST_IDLE;
          // Empty frames publish nothing; a full output register with no ack drops the result.
          if (cnt_q != 16'd0) begin
            if (!out_valid_q || out_ready) begin
              out_valid_q <= 1'b1;
              avg_r_q     <= avg8(sum_r_q);
              avg_g_q     <= avg8(sum_g_q);
              avg_b_q     <= avg8(sum_b_q);
              height_q    <= height_d;
              pix_q       <= cnt_q;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign avg_red       = avg_r_q;
  assign avg_green     = avg_g_q;
  assign avg_blue      = avg_b_q;
  assign height_rows   = height_q;
  assign pix_count     = pix_q;
  assign frame_overrun = overrun_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ov7670_frame_stats.sv
// Randomized self-checking bench for ov7670_frame_stats against a per-pixel arithmetic model.
module tb_ov7670_frame_stats;

  localparam int SH = 3;

  logic        clk = 1'b0;
  logic        rst, ena, cam_vsync, cam_href, cam_pclk, out_ready;
  logic [7:0]  cam_d;
  logic        out_valid, frame_overrun, busy;
  logic [7:0]  avg_red, avg_green, avg_blue, height_rows;
  logic [15:0] pix_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] fpx [0:7][0:7];
  int nl, np;
  int e_r, e_g, e_b, e_h, e_cnt;
  int a_r, a_g, a_b, a_h, a_cnt;

  always #5 clk = ~clk;

  ov7670_frame_stats #(.AVG_SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cam_d(cam_d), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_pclk(cam_pclk), .out_valid(out_valid), .out_ready(out_ready),
    .avg_red(avg_red), .avg_green(avg_green), .avg_blue(avg_blue),
    .height_rows(height_rows), .pix_count(pix_count), .frame_overrun(frame_overrun), .busy(busy)
  );

  // Reference: expand each RGB565 pixel, sum, average, and find rows holding green-dominant pixels.
  task automatic model_frame();
    int sr, sg, sb, minl, maxl, r5, g6, b5;
    sr = 0; sg = 0; sb = 0; minl = -1; maxl = -1;
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < np; p++) begin
        r5 = int'(fpx[l][p][15:11]);
        g6 = int'(fpx[l][p][10:5]);
        b5 = int'(fpx[l][p][4:0]);
        sr += r5 * 8; sg += g6 * 4; sb += b5 * 8;
        if (g6 > 2 * r5 && g6 > 2 * b5) begin
          if (minl < 0) minl = l;
          maxl = l;
        end
      end
    end
    e_r = ((sr >> SH) > 255) ? 255 : (sr >> SH);
    e_g = ((sg >> SH) > 255) ? 255 : (sg >> SH);
    e_b = ((sb >> SH) > 255) ? 255 : (sb >> SH);
    e_h = (minl < 0) ? 0 : (maxl - minl + 1);
    e_cnt = nl * np;
  endtask

  task automatic fill_const(input int lines, input int pixels, input logic [15:0] px);
    nl = lines; np = pixels;
    for (int l = 0; l < 8; l++) for (int p = 0; p < 8; p++) fpx[l][p] = px;
  endtask

  task automatic fill_rand(input int lines, input int pixels);
    nl = lines; np = pixels;
    for (int l = 0; l < 8; l++) begin
      for (int p = 0; p < 8; p++) begin
        if ($urandom_range(2, 0) == 0)
          fpx[l][p] = {5'($urandom_range(7, 0)), 6'($urandom_range(63, 40)), 5'($urandom_range(7, 0))};
        else
          fpx[l][p] = 16'($urandom);
      end
    end
  endtask

  task automatic pclk_cycle(input logic [7:0] d, input logic h);
    cam_d = d; cam_href = h;
    #40 cam_pclk = 1'b1;
    #40 cam_pclk = 1'b0;
  endtask

  task automatic frame_lead();
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (3) pclk_cycle(8'h00, 1'b0);
    cam_vsync = 1'b0;
    repeat (3) pclk_cycle(8'h00, 1'b0);
  endtask

  task automatic send_line(input int l);
    for (int p = 0; p < np; p++) begin
      pclk_cycle(fpx[l][p][15:8], 1'b1);
      pclk_cycle(fpx[l][p][7:0], 1'b1);
    end
    repeat (3) pclk_cycle(8'h00, 1'b0);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    repeat (4) pclk_cycle(8'h00, 1'b0);
    @(negedge clk);
  endtask

  task automatic send_frame();
    frame_lead();
    for (int l = 0; l < nl; l++) send_line(l);
    frame_end();
  endtask

  task automatic ack_result();
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ack_clear: out_valid=%0b expected 0", out_valid);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_pclk = 1'b0;
    cam_d = 8'h00; out_ready = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({out_valid, busy, frame_overrun, avg_red, avg_green, avg_blue, height_rows, pix_count} !== 51'd0) begin
      n_fail++;
      $display("FAIL reset_state: v=%0b busy=%0b ovr=%0b r=%0d g=%0d b=%0d h=%0d n=%0d expected all 0",
               out_valid, busy, frame_overrun, avg_red, avg_green, avg_blue, height_rows, pix_count);
    end
  endtask

  task automatic test_const_frames();
    logic [15:0] pats [0:2];
    int          dims [0:2];
    pats[0] = 16'h07E0; pats[1] = 16'hF800; pats[2] = 16'hFFFF;
    dims[0] = 2; dims[1] = 2; dims[2] = 3;
    for (int k = 0; k < 3; k++) begin
      fill_const(dims[k], 4, pats[k]);
      model_frame();
      send_frame();
      n_tests++;
      if ({out_valid, avg_red, avg_green, avg_blue, height_rows, pix_count} !==
          {1'b1, 8'(e_r), 8'(e_g), 8'(e_b), 8'(e_h), 16'(e_cnt)}) begin
        n_fail++;
        $display("FAIL const_frame_%0d: v=%0b r=%0d g=%0d b=%0d h=%0d n=%0d expected v=1 r=%0d g=%0d b=%0d h=%0d n=%0d",
                 k, out_valid, avg_red, avg_green, avg_blue, height_rows, pix_count, e_r, e_g, e_b, e_h, e_cnt);
      end
      ack_result();
    end
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 5; k++) begin
      fill_rand($urandom_range(5, 1), $urandom_range(6, 1));
      model_frame();
      send_frame();
      n_tests++;
      if ({out_valid, avg_red, avg_green, avg_blue, height_rows, pix_count} !==
          {1'b1, 8'(e_r), 8'(e_g), 8'(e_b), 8'(e_h), 16'(e_cnt)}) begin
        n_fail++;
        $display("FAIL random_frame_%0d: v=%0b r=%0d g=%0d b=%0d h=%0d n=%0d expected v=1 r=%0d g=%0d b=%0d h=%0d n=%0d",
                 k, out_valid, avg_red, avg_green, avg_blue, height_rows, pix_count, e_r, e_g, e_b, e_h, e_cnt);
      end
      ack_result();
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    fill_rand(2, 3); model_frame(); send_frame();
    fill_rand(3, 4); model_frame();
    frame_lead();
    for (int l = 0; l < nl; l++) send_line(l);
    cam_vsync = 1'b1;
    guard = 0;
    @(negedge clk);
    while (busy === 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (guard >= 200) begin
      n_fail++; $display("FAIL b2b_publish_timeout: busy=%0b expected 0 within 200 cycles", busy);
    end
    out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    n_tests++;
    if ({out_valid, frame_overrun, avg_red, avg_green, avg_blue, height_rows, pix_count} !==
        {1'b1, 1'b0, 8'(e_r), 8'(e_g), 8'(e_b), 8'(e_h), 16'(e_cnt)}) begin
      n_fail++;
      $display("FAIL b2b_load: v=%0b ovr=%0b r=%0d g=%0d b=%0d h=%0d n=%0d expected v=1 ovr=0 r=%0d g=%0d b=%0d h=%0d n=%0d",
               out_valid, frame_overrun, avg_red, avg_green, avg_blue, height_rows, pix_count, e_r, e_g, e_b, e_h, e_cnt);
    end
    repeat (4) pclk_cycle(8'h00, 1'b0);
    ack_result();
  endtask

  task automatic test_overrun();
    fill_const(2, 4, 16'h07E0); model_frame(); send_frame();
    a_r = e_r; a_g = e_g; a_b = e_b; a_h = e_h; a_cnt = e_cnt;
    fill_rand(3, 5); model_frame(); send_frame();
    n_tests++;
    if ({out_valid, frame_overrun, avg_red, avg_green, avg_blue, height_rows, pix_count} !==
        {1'b1, 1'b1, 8'(a_r), 8'(a_g), 8'(a_b), 8'(a_h), 16'(a_cnt)}) begin
      n_fail++;
      $display("FAIL overrun_hold: v=%0b ovr=%0b r=%0d g=%0d b=%0d h=%0d n=%0d expected v=1 ovr=1 r=%0d g=%0d b=%0d h=%0d n=%0d",
               out_valid, frame_overrun, avg_red, avg_green, avg_blue, height_rows, pix_count, a_r, a_g, a_b, a_h, a_cnt);
    end
    ack_result();
    n_tests++;
    if (frame_overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_sticky: ovr=%0b expected 1", frame_overrun);
    end
  endtask

  task automatic test_abort();
    fill_rand(2, 3);
    frame_lead(); send_line(0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_active: busy=%0b expected 1", busy);
    end
    ena = 1'b0;
    repeat (2) pclk_cycle(8'h00, 1'b0);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL ena_abort_busy: busy=%0b expected 0", busy);
    end
    ena = 1'b1;
    send_line(1); frame_end();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ena_abort_publish: out_valid=%0b expected 0", out_valid);
    end
    frame_lead(); send_line(0);
    do_reset();
    n_tests++;
    if ({busy, frame_overrun, out_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rst_midframe: busy=%0b ovr=%0b v=%0b expected 0 0 0", busy, frame_overrun, out_valid);
    end
    send_line(1); frame_end();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_abort_publish: out_valid=%0b expected 0", out_valid);
    end
    fill_rand(3, 2); model_frame(); send_frame();
    n_tests++;
    if ({out_valid, avg_red, avg_green, avg_blue, height_rows, pix_count} !==
        {1'b1, 8'(e_r), 8'(e_g), 8'(e_b), 8'(e_h), 16'(e_cnt)}) begin
      n_fail++;
      $display("FAIL after_abort_frame: v=%0b r=%0d g=%0d b=%0d h=%0d n=%0d expected v=1 r=%0d g=%0d b=%0d h=%0d n=%0d",
               out_valid, avg_red, avg_green, avg_blue, height_rows, pix_count, e_r, e_g, e_b, e_h, e_cnt);
    end
    ack_result();
  endtask

  task automatic test_no_samples();
    frame_lead();
    for (int l = 0; l < 2; l++) begin
      cam_href = 1'b1; cam_d = 8'($urandom);
      #80 cam_href = 1'b0;
      repeat (3) pclk_cycle(8'($urandom), 1'b0);
    end
    frame_end();
    n_tests++;
    if ({out_valid, busy, pix_count} !== {1'b0, 1'b0, 16'(e_cnt)}) begin
      n_fail++;
      $display("FAIL no_sample_frame: v=%0b busy=%0b n=%0d expected v=0 busy=0 n=%0d", out_valid, busy, pix_count, e_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_const_frames();
    test_random_frames();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_no_samples();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
